// File: rtl/axis_lane_accum.sv
// AXI-Stream lane-reduction accumulator.
// Each accepted beat is split into lanes and the lanes are summed in a registered stage.
// The lane sums are accumulated over a frame, and one result beat is emitted per frame.
module axis_lane_accum #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned OUT_WIDTH  = 64,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    input  logic [15:0]           cfg_len,
    input  logic                  clear,
    output logic                  busy,
    output logic                  ovf_sticky,
    output logic [31:0]           frame_count
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    // Low-bit masks; when widths are equal the shift yields 0 and the mask becomes all ones.
    localparam logic [ACC_WIDTH-1:0] LANE_MASK = (ACC_WIDTH'(1) << LANE_WIDTH) - ACC_WIDTH'(1);
    localparam logic [OUT_WIDTH-1:0] ACC_MASK  = (OUT_WIDTH'(1) << ACC_WIDTH) - OUT_WIDTH'(1);

    typedef enum logic [1:0] {StAccum, StDrain, StOut} state_e;

    state_e                 state_q, state_d;
    logic                   accept, frame_end, handshake;
    logic [15:0]            cnt_q, len_q, eff_len;
    logic                   started_q;
    logic [ACC_WIDTH-1:0]   lane_ext, lsum_d, lsum_q, acc_q, acc_sum;
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   lsum_vld_q, add_ovf, ovf_q;
    logic [OUT_WIDTH-1:0]   acc_ext, tdata_q;
    logic                   tvalid_q, tuser_q, ovf_sticky_q;
    logic [31:0]            frame_count_q;

    assign accept    = s_axis_tvalid && s_axis_tready;
    // clear wins over a simultaneous output handshake.
    assign handshake = tvalid_q && m_axis_tready && !clear;
    // cfg_len is live only on the first beat of a frame, then the latched copy applies.
    assign eff_len   = started_q ? len_q : cfg_len;
    assign frame_end = accept && (s_axis_tlast ||
                                  (eff_len != 16'd0 && (cnt_q + 16'd1) == eff_len));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (frame_end) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   if (handshake) state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        s_axis_tready = rstn && !clear && (state_q == StAccum);
        busy          = (state_q != StAccum) || started_q;
    end

    // Stage-1 lane reduction, each lane extended to the accumulator width
    always_comb begin
        lsum_d   = '0;
        lane_ext = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_ext = ACC_WIDTH'(s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH]);
            if (SIGNED && s_axis_tdata[i*LANE_WIDTH + LANE_WIDTH - 1]) begin
                lane_ext = lane_ext | ~LANE_MASK;
            end
            lsum_d = lsum_d + lane_ext;
        end
    end

    // Stage-2 add with carry/overflow detection, and result extension
    always_comb begin
        sum_wide = {1'b0, acc_q} + {1'b0, lsum_q};
        acc_sum  = sum_wide[ACC_WIDTH-1:0];
        if (SIGNED) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == lsum_q[ACC_WIDTH-1]) &&
                      (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_wide[ACC_WIDTH];
        end
        acc_ext = OUT_WIDTH'(acc_q);
        if (SIGNED && acc_q[ACC_WIDTH-1]) begin
            acc_ext = acc_ext | ~ACC_MASK;
        end
    end

    // Datapath, frame bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            cnt_q         <= '0;
            len_q         <= '0;
            started_q     <= 1'b0;
            lsum_q        <= '0;
            lsum_vld_q    <= 1'b0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tuser_q       <= 1'b0;
            ovf_sticky_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            lsum_vld_q <= accept;
            if (accept) begin
                lsum_q    <= lsum_d;
                cnt_q     <= cnt_q + 16'd1;
                started_q <= 1'b1;
                if (!started_q) len_q <= cfg_len;
            end
            if (lsum_vld_q) begin
                acc_q <= acc_sum;
                if (add_ovf) ovf_q <= 1'b1;
            end
            // The final lane sum lands during DRAIN, so the result is captured once in OUT.
            if (state_q == StOut && !tvalid_q) begin
                tvalid_q <= 1'b1;
                tdata_q  <= acc_ext;
                tuser_q  <= ovf_q;
            end
            if (handshake) begin
                tvalid_q      <= 1'b0;
                acc_q         <= '0;
                ovf_q         <= 1'b0;
                cnt_q         <= '0;
                started_q     <= 1'b0;
                frame_count_q <= frame_count_q + 32'd1;
                ovf_sticky_q  <= ovf_sticky_q | tuser_q;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign ovf_sticky    = ovf_sticky_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_lane_accum.sv
// Directed bench for axis_lane_accum: default, signed and narrow-accumulator instances
// share one stimulus stream; each result is checked against hand-computed values.
module tb_axis_lane_accum;

    logic        clk = 1'b0;
    logic        rstn, s_tvalid, s_tlast, m_tready, clear;
    logic [63:0] s_tdata;
    logic [15:0] cfg_len;

    logic        d_tready, d_tvalid, d_tuser, d_busy, d_sticky;
    logic        g_tready, g_tvalid, g_tuser, g_busy, g_sticky;
    logic        w_tready, w_tvalid, w_tuser, w_busy, w_sticky;
    logic [63:0] d_tdata, g_tdata, w_tdata;
    logic [31:0] d_fc, g_fc, w_fc;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] dd, gd, wd;
    logic        du, gu, wu;

    typedef struct {
        logic [31:0] l1;
        logic [31:0] l0;
        logic [63:0] exp_d;
        logic [63:0] exp_g;
        logic [63:0] exp_w;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    axis_lane_accum u_def (
        .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(d_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(d_tdata),
        .m_axis_tvalid(d_tvalid), .m_axis_tready(m_tready), .m_axis_tuser(d_tuser),
        .cfg_len(cfg_len), .clear(clear), .busy(d_busy), .ovf_sticky(d_sticky),
        .frame_count(d_fc)
    );

    axis_lane_accum #(.SIGNED(1'b1)) u_sgn (
        .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(g_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(g_tdata),
        .m_axis_tvalid(g_tvalid), .m_axis_tready(m_tready), .m_axis_tuser(g_tuser),
        .cfg_len(cfg_len), .clear(clear), .busy(g_busy), .ovf_sticky(g_sticky),
        .frame_count(g_fc)
    );

    axis_lane_accum #(.ACC_WIDTH(33)) u_w33 (
        .clk(clk), .rstn(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(w_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(w_tdata),
        .m_axis_tvalid(w_tvalid), .m_axis_tready(m_tready), .m_axis_tuser(w_tuser),
        .cfg_len(cfg_len), .clear(clear), .busy(w_busy), .ovf_sticky(w_sticky),
        .frame_count(w_fc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until the default instance accepts it.
    task automatic send(input logic [31:0] l1, input logic [31:0] l0, input logic last);
        int n = 0;
        @(negedge clk);
        s_tdata  = {l1, l0};
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!d_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!d_tready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: s_axis_tready never rose within %0d cycles", n);
            s_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!d_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!d_tvalid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL valid_timeout: m_axis_tvalid still 0 after %0d cycles", n);
        end
    endtask

    // Wait for a result, capture all three instances, then handshake it.
    task automatic take(output logic [63:0] od, output logic [63:0] og, output logic [63:0] ow,
                        output logic oud, output logic oug, output logic ouw);
        wait_valid();
        @(negedge clk);
        od  = d_tdata;
        og  = g_tdata;
        ow  = w_tdata;
        oud = d_tuser;
        oug = g_tuser;
        ouw = w_tuser;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        m_tready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h2, 32'h1, 64'h3, 64'h3, 64'h3};
        vecs[1] = '{32'h3, 32'hFFFF_FFFF, 64'h1_0000_0002, 64'h2, 64'h1_0000_0002};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_FFFF_FFFE,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h1_FFFF_FFFE};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h1_0000_0000,
                    64'hFFFF_FFFF_0000_0000, 64'h1_0000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFE, 64'hFFFF_FFFE, 64'hFFFF_FFFE};
        vecs[5] = '{32'h0, 32'h0, 64'h0, 64'h0, 64'h0};

        rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; clear = 1'b0;
        s_tdata = '0; cfg_len = '0;
        @(negedge clk);
        chk("rst_tready_low", d_tready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", d_tvalid, 0);
        chk("rst_tdata", d_tdata, 0);
        chk("rst_tuser", d_tuser, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_sticky", d_sticky, 0);
        chk("rst_fc", d_fc, 0);
        chk("rst_tready_up", d_tready, 1);

        // Four-beat frame on tlast; result valid two edges after the last accept.
        send(32'd2, 32'd1, 1'b0);
        chk("t1_busy", d_busy, 1);
        send(32'd4, 32'd3, 1'b0);
        send(32'd6, 32'd5, 1'b0);
        send(32'd8, 32'd7, 1'b1);
        @(negedge clk);
        chk("t1_drain_tready", d_tready, 0);
        chk("t1_lat_a", d_tvalid, 0);
        @(negedge clk);
        chk("t1_lat_b", d_tvalid, 0);
        chk("t1_out_tready", d_tready, 0);
        @(negedge clk);
        chk("t1_lat_c", d_tvalid, 1);
        take(dd, gd, wd, du, gu, wu);
        chk("t1_sum", dd, 64'd36);
        chk("t1_sum_sgn", gd, 64'd36);
        chk("t1_tuser", du, 0);
        chk("t1_fc", d_fc, 1);
        chk("t1_tvalid_low", d_tvalid, 0);

        // cfg_len=3 frames; a mid-frame change of cfg_len must not move the frame end.
        pulse_clear();
        chk("t2_clr_fc", d_fc, 0);
        cfg_len = 16'd3;
        send(32'd1, 32'd1, 1'b0);
        cfg_len = 16'd0;
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        @(negedge clk);
        chk("t2_drain_tready", d_tready, 0);
        take(dd, gd, wd, du, gu, wu);
        chk("t2_sum_a", dd, 64'd6);
        cfg_len = 16'd3;
        send(32'd1, 32'd1, 1'b0);
        cfg_len = 16'd5;
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        take(dd, gd, wd, du, gu, wu);
        chk("t2_sum_b", dd, 64'd6);
        chk("t2_fc", d_fc, 2);
        cfg_len = 16'd0;

        // Backpressure: result held 10 cycles while an upstream beat waits.
        send(32'd5, 32'd5, 1'b1);
        fork
            send(32'd2, 32'd1, 1'b1);
            begin
                logic [63:0] td0;
                int stab = 0;
                int rdy = 0;
                wait_valid();
                td0 = d_tdata;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (d_tdata !== td0 || d_tuser !== 1'b0 || d_tvalid !== 1'b1) stab++;
                    if (d_tready) rdy++;
                end
                chk("t3_stable", 64'(stab), 0);
                chk("t3_tready_low", 64'(rdy), 0);
                take(dd, gd, wd, du, gu, wu);
                chk("t3_sum_a", dd, 64'd10);
            end
        join
        take(dd, gd, wd, du, gu, wu);
        chk("t3_sum_b", dd, 64'd3);

        // Single-beat frames across all three instance flavours.
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].l1, vecs[v].l0, 1'b1);
            take(dd, gd, wd, du, gu, wu);
            chk($sformatf("vec%0d_def", v), dd, vecs[v].exp_d);
            chk($sformatf("vec%0d_sgn", v), gd, vecs[v].exp_g);
            chk($sformatf("vec%0d_w33", v), wd, vecs[v].exp_w);
            chk($sformatf("vec%0d_tuser", v), du, 0);
        end

        // Carry out of a 33-bit accumulator.
        pulse_clear();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_valid();
        chk("t5_sticky_pre", w_sticky, 0);
        take(dd, gd, wd, du, gu, wu);
        chk("t5_w33_sum", wd, 64'h1_FFFF_FFFC);
        chk("t5_w33_tuser", wu, 1);
        chk("t5_def_sum", dd, 64'h3_FFFF_FFFC);
        chk("t5_def_tuser", du, 0);
        chk("t5_sgn_sum", gd, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_sgn_tuser", gu, 0);
        chk("t5_w33_sticky", w_sticky, 1);
        chk("t5_def_sticky", d_sticky, 0);

        // clear mid-frame, clear against a pending handshake, then reset in OUT.
        pulse_clear();
        chk("t6_sticky_clr", w_sticky, 0);
        send(32'd1, 32'd1, 1'b0);
        send(32'd1, 32'd1, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("t6_clr_tready", d_tready, 0);
        @(negedge clk);
        clear = 1'b0;
        chk("t6_busy", d_busy, 0);
        send(32'd10, 32'd10, 1'b1);
        wait_valid();
        @(negedge clk);
        clear = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_tready = 1'b0;
        chk("t6_drop_tvalid", d_tvalid, 0);
        chk("t6_drop_fc", d_fc, 0);
        send(32'd3, 32'd4, 1'b1);
        take(dd, gd, wd, du, gu, wu);
        chk("t6_sum", dd, 64'd7);
        chk("t6_fc", d_fc, 1);
        send(32'd1, 32'd1, 1'b1);
        wait_valid();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t6_rst_tvalid", d_tvalid, 0);
        chk("t6_rst_tdata", d_tdata, 0);
        chk("t6_rst_fc", d_fc, 0);
        chk("t6_rst_busy", d_busy, 0);
        @(negedge clk);
        chk("t6_rst_tready", d_tready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
